sdrc_req_arb: RTL and testbench

Four-port request arbiter that shares the single application request interface of the SDRAM request generator between four independent requesters (e.g. CPU, DMA, display, bridge). Arbitration is round-robin, with a per-port enable mask. The block tags each forwarded request with the originating port number in the request ID. It sits between the application ports and the request generator's req/req_ack handshake.

---
 rtl/sdrc_req_arb.sv | 133 +++++++++++++
 tb/tb_sdrc_req_arb.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdrc_req_arb.sv
// sdrc_req_arb: four-port round-robin arbiter sharing the SDRAM request generator's req/req_ack port.
// Optional build macro SDRC_ARB_P0_PRIO_EN gives port 0 strict priority, capped at P0_MAX_GNT grants in a row.
module sdrc_req_arb #(
   parameter int unsigned APP_AW = 30,
   parameter int unsigned APP_RW = 9,
   parameter int unsigned ID_W   = 4
`ifdef SDRC_ARB_P0_PRIO_EN
   ,
   parameter int unsigned P0_MAX_GNT = 4
`endif
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [3:0]            cfg_port_en,
   input  logic [3:0]            p_req,
   input  logic [4*(ID_W-2)-1:0] p_id,
   input  logic [4*APP_AW-1:0]   p_addr,
   input  logic [4*APP_RW-1:0]   p_len,
   input  logic [3:0]            p_wr_n,
   input  logic [3:0]            p_wrap,
   output logic [3:0]            p_ack,
   output logic                  m_req,
   output logic [ID_W-1:0]       m_req_id,
   output logic [APP_AW-1:0]     m_req_addr,
   output logic [APP_RW-1:0]     m_req_len,
   output logic                  m_req_wr_n,
   output logic                  m_req_wrap,
   input  logic                  m_req_ack,
   output logic                  arb_idle,
   output logic [1:0]            grant_idx
);
   localparam int unsigned TAG_W = ID_W - 2;

   typedef enum logic {ARB_IDLE = 1'b0, ARB_GRANT = 1'b1} arb_state_t;

   arb_state_t state;
   logic [1:0] rr_ptr;
   logic [3:0] eligible;
   logic       accept;
   logic [1:0] rr_pick;
   logic [1:0] next_grant;

   assign eligible = p_req & cfg_port_en;
   assign accept   = (state == ARB_GRANT) && m_req_ack;

   // First eligible port at or after rr_ptr; the smallest offset wins.
   always_comb begin
      rr_pick = rr_ptr;
      for (int i = 3; i >= 0; i--) begin
         if (eligible[rr_ptr + 2'(i)]) rr_pick = rr_ptr + 2'(i);
      end
   end

`ifdef SDRC_ARB_P0_PRIO_EN
   logic [2:0] p0_cnt;
   logic       p0_skip;
   logic [1:0] hi_pick;

   assign p0_skip = (p0_cnt == 3'(P0_MAX_GNT)) && (eligible[3:1] != 3'b000);

   // Search restarted at port 1 when port 0 gives way for one round.
   always_comb begin
      hi_pick = 2'd1;
      for (int i = 3; i >= 1; i--) begin
         if (eligible[i]) hi_pick = 2'(i);
      end
   end

   always_comb begin
      next_grant = rr_pick;
      if (eligible[0]) next_grant = p0_skip ? hi_pick : 2'd0;
   end

   // Consecutive port-0 accepts; saturates at the cap until another port wins.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         p0_cnt <= 3'd0;
      end else if (accept) begin
         if (grant_idx != 2'd0)                 p0_cnt <= 3'd0;
         else if (p0_cnt != 3'(P0_MAX_GNT))     p0_cnt <= p0_cnt + 3'd1;
      end else if ((state == ARB_IDLE) && (eligible != 4'b0000) &&
                   (!eligible[0] || p0_skip)) begin
         p0_cnt <= 3'd0;
      end
   end
`else
   assign next_grant = rr_pick;
`endif

   // Arbitration state, grant lock and rotation pointer.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= ARB_IDLE;
         grant_idx <= 2'd0;
         rr_ptr    <= 2'd0;
         m_req     <= 1'b0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (eligible != 4'b0000) begin
                  grant_idx <= next_grant;
                  state     <= ARB_GRANT;
                  m_req     <= 1'b1;
               end
            end
            ARB_GRANT: begin
               if (m_req_ack) begin
                  rr_ptr <= grant_idx + 2'd1;
                  state  <= ARB_IDLE;
                  m_req  <= 1'b0;
               end
            end
            default: begin
               state <= ARB_IDLE;
               m_req <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      p_ack = 4'b0000;
      if (accept) p_ack[grant_idx] = 1'b1;
   end

   assign arb_idle   = (state == ARB_IDLE) && (eligible == 4'b0000);
   assign m_req_id   = {grant_idx, p_id[int'(grant_idx) * TAG_W +: TAG_W]};
   assign m_req_addr = p_addr[int'(grant_idx) * APP_AW +: APP_AW];
   assign m_req_len  = p_len[int'(grant_idx) * APP_RW +: APP_RW];
   assign m_req_wr_n = p_wr_n[grant_idx];
   assign m_req_wrap = p_wrap[grant_idx];

endmodule

// File: tb/tb_sdrc_req_arb.sv
// Scoreboard bench for sdrc_req_arb: expected grant ports are queued as requests are driven
// and checked, field by field, each time the arbiter presents m_req.
module tb_sdrc_req_arb;
   localparam int unsigned AW = 30;
   localparam int unsigned RW = 9;
   localparam int unsigned IW = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [3:0]    cfg_port_en;
   logic [3:0]    p_req;
   logic [7:0]    p_id;
   logic [4*AW-1:0] p_addr;
   logic [4*RW-1:0] p_len;
   logic [3:0]    p_wr_n;
   logic [3:0]    p_wrap;
   logic [3:0]    p_ack;
   logic          m_req;
   logic [IW-1:0] m_req_id;
   logic [AW-1:0] m_req_addr;
   logic [RW-1:0] m_req_len;
   logic          m_req_wr_n;
   logic          m_req_wrap;
   logic          m_req_ack;
   logic          arb_idle;
   logic [1:0]    grant_idx;

   logic [1:0]    f_id   [4];
   logic [AW-1:0] f_addr [4];
   logic [RW-1:0] f_len  [4];
   logic          f_wr_n [4];
   logic          f_wrap [4];

   logic [1:0]    exp_q[$];
   int            errors = 0;
   int            checks = 0;

   sdrc_req_arb #(.APP_AW(AW), .APP_RW(RW), .ID_W(IW)) dut (
      .clk(clk), .reset_n(reset_n), .cfg_port_en(cfg_port_en), .p_req(p_req),
      .p_id(p_id), .p_addr(p_addr), .p_len(p_len), .p_wr_n(p_wr_n), .p_wrap(p_wrap),
      .p_ack(p_ack), .m_req(m_req), .m_req_id(m_req_id), .m_req_addr(m_req_addr),
      .m_req_len(m_req_len), .m_req_wr_n(m_req_wr_n), .m_req_wrap(m_req_wrap),
      .m_req_ack(m_req_ack), .arb_idle(arb_idle), .grant_idx(grant_idx)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset_n   = 1'b0;
      m_req_ack = 1'b0;
      p_req     = 4'b0000;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic wait_grant(input int budget);
      int n = 0;
      tick();
      n++;
      while (m_req !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      if (m_req !== 1'b1) check("grant_timeout", 64'(m_req), 64'd1);
   endtask

   // Compare the presented request with the queue head, ack it, and check the gap cycle.
   task automatic serve(input logic drop);
      logic [1:0] e;
      logic [3:0] one_hot;
      if (exp_q.size() == 0) begin
         check("queue_empty", 64'(exp_q.size()), 64'd1);
         return;
      end
      e = exp_q.pop_front();
      one_hot = 4'b0001 << e;
      check("grant_idx", 64'(grant_idx), 64'(e));
      check("m_req_id", 64'(m_req_id), 64'({e, f_id[e]}));
      check("m_req_addr", 64'(m_req_addr), 64'(f_addr[e]));
      check("m_req_len", 64'(m_req_len), 64'(f_len[e]));
      check("m_req_wr_n", 64'(m_req_wr_n), 64'(f_wr_n[e]));
      check("m_req_wrap", 64'(m_req_wrap), 64'(f_wrap[e]));
      m_req_ack = 1'b1;
      #1;
      check("p_ack", 64'(p_ack), 64'(one_hot));
      tick();
      m_req_ack = 1'b0;
      if (drop) p_req[e] = 1'b0;
      #1;
      check("gap_m_req", 64'(m_req), 64'd0);
      check("p_ack_pulse", 64'(p_ack), 64'd0);
   endtask

   initial begin
      logic [1:0] seq[$];

      f_id   = '{2'b10, 2'b01, 2'b11, 2'b00};
      f_addr = '{30'h100, 30'h2345678, 30'h3FFFFFFF, 30'h1};
      f_len  = '{9'd8, 9'h1FF, 9'd0, 9'h0AA};
      f_wr_n = '{1'b0, 1'b1, 1'b0, 1'b1};
      f_wrap = '{1'b1, 1'b0, 1'b0, 1'b1};
      for (int n = 0; n < 4; n++) begin
         p_id[n*2 +: 2]    = f_id[n];
         p_addr[n*AW +: AW] = f_addr[n];
         p_len[n*RW +: RW]  = f_len[n];
         p_wr_n[n]          = f_wr_n[n];
         p_wrap[n]          = f_wrap[n];
      end
      cfg_port_en = 4'hF;
      do_reset();
      #1;
      check("rst_m_req", 64'(m_req), 64'd0);
      check("rst_p_ack", 64'(p_ack), 64'd0);
      check("rst_arb_idle", 64'(arb_idle), 64'd1);
      check("rst_grant_idx", 64'(grant_idx), 64'd0);

      // Single request on port 0, one-clock latency.
      tick();
      p_req = 4'b0001;
      exp_q.push_back(2'd0);
      wait_grant(1);
      serve(1'b1);
      check("idle_after_drop", 64'(arb_idle), 64'd1);

      // All ports requesting continuously.
      do_reset();
      p_req = 4'b1111;
`ifdef SDRC_ARB_P0_PRIO_EN
      seq = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
`else
      seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`endif
      foreach (seq[k]) exp_q.push_back(seq[k]);
      foreach (seq[k]) begin
         wait_grant(1);
         serve(1'b0);
      end
      p_req = 4'b0000;

      // Disabled requester is ignored until enabled.
      tick();
      cfg_port_en = 4'b1011;
      p_req = 4'b0100;
      repeat (3) tick();
      check("dis_m_req", 64'(m_req), 64'd0);
      check("dis_arb_idle", 64'(arb_idle), 64'd1);
      cfg_port_en = 4'hF;
      exp_q.push_back(2'd2);
      wait_grant(1);
      serve(1'b1);

      // Grant lock while the generator stalls.
      p_req = 4'b0010;
      exp_q.push_back(2'd1);
      wait_grant(1);
      p_req[3] = 1'b1;
      cfg_port_en[1] = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (m_req !== 1'b1 || grant_idx !== 2'd1 || m_req_addr !== f_addr[1])
            check("lock_hold", 64'({m_req, grant_idx, m_req_addr}), 64'({1'b1, 2'd1, f_addr[1]}));
      end
      check("lock_grant_idx", 64'(grant_idx), 64'd1);
      check("lock_m_req_len", 64'(m_req_len), 64'(f_len[1]));
      serve(1'b1);
      cfg_port_en = 4'hF;
      exp_q.push_back(2'd3);
      wait_grant(1);
      serve(1'b1);

      // Reset mid-grant drops the transfer and restarts rotation from port 0.
      p_req = 4'b0100;
      exp_q.push_back(2'd2);
      wait_grant(1);
      serve(1'b1);
      p_req = 4'b0010;
      wait_grant(1);
      check("pre_rst_grant", 64'(grant_idx), 64'd1);
      reset_n = 1'b0;
      p_req   = 4'b0000;
      tick();
      #1;
      check("mid_rst_m_req", 64'(m_req), 64'd0);
      check("mid_rst_p_ack", 64'(p_ack), 64'd0);
      check("mid_rst_grant_idx", 64'(grant_idx), 64'd0);
      check("mid_rst_arb_idle", 64'(arb_idle), 64'd1);
      reset_n = 1'b1;
      p_req = 4'b1011;
      exp_q.push_back(2'd0);
      wait_grant(1);
      serve(1'b0);
      p_req = 4'b0000;

      // Stray ack while idle, and every port disabled.
      tick();
      m_req_ack = 1'b1;
      #1;
      check("idle_ack_p_ack", 64'(p_ack), 64'd0);
      tick();
      m_req_ack = 1'b0;
      #1;
      check("idle_ack_m_req", 64'(m_req), 64'd0);
      cfg_port_en = 4'b0000;
      p_req = 4'b1111;
      repeat (3) tick();
      check("all_dis_m_req", 64'(m_req), 64'd0);
      check("all_dis_arb_idle", 64'(arb_idle), 64'd1);
      p_req = 4'b0000;
      cfg_port_en = 4'hF;

      // Ports 0 and 2 both held.
      do_reset();
      p_req = 4'b0101;
`ifdef SDRC_ARB_P0_PRIO_EN
      seq = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2};
`else
      seq = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2};
`endif
      foreach (seq[k]) exp_q.push_back(seq[k]);
      foreach (seq[k]) begin
         wait_grant(1);
         serve(1'b0);
      end
      p_req = 4'b0000;
      tick();

      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
